rv_mem_arb: RTL and testbench

- Shares the single memory port between two requesters: the multicycle core (port C) and the debug/program loader (port D).
- The memory itself is fixed-latency.
- The block arbitrates between the requesters and sequences each access through a small FSM.
- It returns a one-cycle completion strobe with read data to the owning requester.
- It sits between the core's memory interface (memrw/address/data) and the memory instance.

---
 rtl/rv_mem_pkg.sv | 12 +
 rtl/rv_rr_arb2.sv | 20 ++
 rtl/rv_mem_arb.sv | 140 ++++++++++++++
 tb/tb_rv_mem_arb.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// Shared state encoding, owner ids and counter width for the memory-port arbiter.
package rv_mem_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_DBG  = 1'b1;
  localparam int   LAT_W    = 4;
endpackage

// File: rtl/rv_rr_arb2.sv
// Two-input round-robin picker; purely combinational, zero latency.
// A tie goes to the port that was not served last; no backpressure of its own.
module rv_rr_arb2
  import rv_mem_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_served,
  output logic gnt0,
  output logic gnt1,
  output logic winner
);

  always_comb begin
    gnt0   = req0 & (~req1 | (last_served == OWN_DBG));
    gnt1   = req1 & (~req0 | (last_served == OWN_CORE));
    winner = gnt1 ? OWN_DBG : OWN_CORE;
  end

endmodule

// File: rtl/rv_mem_arb.sv
// Shares one fixed-latency memory port between core and debug; gnt same cycle, rvalid MEM_LAT+1 after.
// Losing requester simply holds req (no queueing); one access in flight, MEM_LAT+2 cycles each.
module rv_mem_arb
  import rv_mem_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner,
  output logic          busy
);

  generate
    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
      $error("rv_mem_arb: MEM_LAT must be in 1..15");
    end
  endgenerate

  state_t           state, state_nxt;
  logic [LAT_W-1:0] cnt;
  logic             last_served;
  logic             own_q;
  logic             we_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic [DW-1:0]    rdata_q;
  logic             arb_gnt0, arb_gnt1, arb_win;

  rv_rr_arb2 u_arb (
    .req0        (c_req),
    .req1        (d_req),
    .last_served (last_served),
    .gnt0        (arb_gnt0),
    .gnt1        (arb_gnt1),
    .winner      (arb_win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_gnt0 | arb_gnt1) state_nxt = ACCESS;
      ACCESS:  if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      own_q       <= OWN_CORE;
      last_served <= OWN_DBG;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_gnt0 | arb_gnt1) begin
            own_q   <= arb_win;
            we_q    <= (arb_win == OWN_DBG) ? d_we    : c_we;
            addr_q  <= (arb_win == OWN_DBG) ? d_addr  : c_addr;
            wdata_q <= (arb_win == OWN_DBG) ? d_wdata : c_wdata;
            cnt     <= LAT_W'(MEM_LAT - 1);
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (!we_q) rdata_q <= mem_rdata;
            last_served <= own_q;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Grants are masked by rst_n so nothing is advertised while the block is held in reset.
  always_comb begin
    c_gnt    = 1'b0;
    d_gnt    = 1'b0;
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    c_rvalid = 1'b0;
    d_rvalid = 1'b0;
    case (state)
      IDLE: begin
        c_gnt = arb_gnt0 & rst_n;
        d_gnt = arb_gnt1 & rst_n;
      end
      ACCESS: begin
        mem_en = 1'b1;
        mem_we = we_q;
      end
      DONE: begin
        c_rvalid = (own_q == OWN_CORE);
        d_rvalid = (own_q == OWN_DBG);
      end
      default: ;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign c_rdata   = rdata_q;
  assign d_rdata   = rdata_q;
  assign owner     = own_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_rv_mem_arb.sv
// Bench for rv_mem_arb: cycle-level transaction model plus directed scenarios,
// a MEM_LAT=2 instance (fully modelled) and a MEM_LAT=1 instance (directed only).
module tb_rv_mem_arb;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          c_req, c_we, c_gnt, c_rvalid;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_en, mem_we, owner, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic          p_c_req, p_c_gnt, p_c_rvalid, p_d_gnt, p_d_rvalid;
  logic [AW-1:0] p_c_addr, p_mem_addr;
  logic [DW-1:0] p_c_rdata, p_d_rdata, p_mem_wdata, p_mem_rdata;
  logic          p_mem_en, p_mem_we, p_owner, p_busy;

  rv_mem_arb #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
  );

  rv_mem_arb #(.AW(AW), .DW(DW), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .c_req(p_c_req), .c_we(1'b0), .c_addr(p_c_addr), .c_wdata('0),
    .c_gnt(p_c_gnt), .c_rvalid(p_c_rvalid), .c_rdata(p_c_rdata),
    .d_req(1'b0), .d_we(1'b0), .d_addr('0), .d_wdata('0),
    .d_gnt(p_d_gnt), .d_rvalid(p_d_rvalid), .d_rdata(p_d_rdata),
    .mem_en(p_mem_en), .mem_we(p_mem_we), .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata),
    .mem_rdata(p_mem_rdata), .owner(p_owner), .busy(p_busy)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Memory seen by the DUT pins, and the model's own shadow of it.
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] sh  [logic [AW-1:0]];

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return DW'(a) ^ 32'hA5A5_0000;
  endfunction
  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction
  function automatic logic [DW-1:0] sh_rd(input logic [AW-1:0] a);
    return sh.exists(a) ? sh[a] : dflt(a);
  endfunction

  always @(negedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
    mem_rdata   = mem_en   ? mem_rd(mem_addr)   : '0;
    p_mem_rdata = p_mem_en ? mem_rd(p_mem_addr) : '0;
  end

  // Transaction model: a grant at cycle g occupies the port for g+1..g+LAT,
  // completes at g+LAT+1 and the port is free again from g+LAT+2.
  bit            m_have = 0;
  int            m_g    = 0;
  bit            m_own, m_last, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  always @(negedge clk) begin : model
    bit acc, done, idle, win, eg_c, eg_d, busy_e;
    acc = 0; done = 0; idle = 0; busy_e = 0;
    if (!rst_n) begin
      m_have = 0; m_last = 1; m_own = 0; m_we = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else begin
      acc    = m_have && cyc > m_g && cyc <= m_g + LAT;
      done   = m_have && cyc == m_g + LAT + 1;
      idle   = !m_have || cyc >= m_g + LAT + 2;
      busy_e = !idle;
      if (done) begin
        if (m_we) sh[m_addr] = m_wdata;
        else      m_rdata = sh_rd(m_addr);
        m_last = m_own;
      end
    end
    eg_c = 0; eg_d = 0; win = 0;
    if (idle && (c_req || d_req)) begin
      win  = (c_req && d_req) ? !m_last : d_req;
      eg_c = !win;
      eg_d = win;
    end
    chk("c_gnt",     c_gnt,     eg_c);
    chk("d_gnt",     d_gnt,     eg_d);
    chk("mem_en",    mem_en,    acc);
    chk("mem_we",    mem_we,    acc && m_we);
    chk("mem_addr",  mem_addr,  m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("c_rvalid",  c_rvalid,  done && !m_own);
    chk("d_rvalid",  d_rvalid,  done && m_own);
    chk("c_rdata",   c_rdata,   m_rdata);
    chk("d_rdata",   d_rdata,   m_rdata);
    chk("owner",     owner,     m_own);
    chk("busy",      busy,      busy_e);
    if (eg_c || eg_d) begin
      m_have  = 1;
      m_g     = cyc;
      m_own   = win;
      m_we    = win ? d_we    : c_we;
      m_addr  = win ? d_addr  : c_addr;
      m_wdata = win ? d_wdata : c_wdata;
    end
  end

  task automatic issue(input bit p, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] w, output int gc);
    if (p) begin d_req = 1; d_we = we; d_addr = a; d_wdata = w; end
    else   begin c_req = 1; c_we = we; c_addr = a; c_wdata = w; end
    gc = -1;
    for (int i = 0; i < 40 && gc < 0; i++) begin
      @(negedge clk);
      if (p ? d_gnt : c_gnt) gc = cyc;
    end
    if (gc < 0) begin
      n_chk++;
      $display("FAIL gnt_timeout: port %0d got no grant, required one within 40 cycles", p);
    end
    @(posedge clk); #1;
    if (p) d_req = 0; else c_req = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, n_we, n_rv, hit, n_cg;
    int gs[$], ws[$], pg[$], pr[$];
    int bad_rd, n_prv;
    rst_n = 0;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    p_c_req = 0; p_c_addr = '0;
    mem[32'h10] = 32'hDEADBEEF;
    sh[32'h10]  = 32'hDEADBEEF;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_mem_en", mem_en, 0);
    @(posedge clk); #1 rst_n = 1;

    // Core read at 0x10
    issue(0, 0, 32'h10, '0, g);
    @(negedge clk);
    chk("t1_en_a", mem_en, 1); chk("t1_addr_a", mem_addr, 32'h10); chk("t1_we_a", mem_we, 0);
    @(negedge clk);
    chk("t1_en_b", mem_en, 1); chk("t1_addr_b", mem_addr, 32'h10);
    @(negedge clk);
    chk("t1_rvalid", c_rvalid, 1); chk("t1_rdata", c_rdata, 32'hDEADBEEF);
    chk("t1_d_rvalid", d_rvalid, 0); chk("t1_latency", cyc - g, 3);
    @(negedge clk);
    chk("t1_rvalid_once", c_rvalid, 0);

    // Debug write at 0x40
    @(posedge clk); #1;
    issue(1, 1, 32'h40, 32'h12345678, g);
    n_we = 0; n_rv = 0;
    repeat (4) begin
      @(negedge clk);
      n_we += int'(mem_we);
      n_rv += int'(d_rvalid);
    end
    chk("t2_we_cycles", n_we, 2);
    chk("t2_rvalid_cycles", n_rv, 1);
    chk("t2_rdata_kept", d_rdata, 32'hDEADBEEF);

    // Core reads back what debug wrote
    @(posedge clk); #1;
    issue(0, 0, 32'h40, '0, g);
    repeat (3) @(negedge clk);
    chk("t2b_rvalid", c_rvalid, 1);
    chk("t2b_rdata", c_rdata, 32'h12345678);

    // Both requesting from reset: core first, then strict alternation
    @(posedge clk); #1 rst_n = 0;
    c_req = 1; c_we = 0; c_addr = 32'h0;
    d_req = 1; d_we = 0; d_addr = 32'h4;
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 40 && gs.size() < 4; i++) begin
      @(negedge clk);
      if (c_gnt) begin gs.push_back(cyc); ws.push_back(0); end
      if (d_gnt) begin gs.push_back(cyc); ws.push_back(1); end
    end
    @(posedge clk); #1 c_req = 0; d_req = 0;
    chk("t3_ngnt", gs.size(), 4);
    if (gs.size() == 4) begin
      chk("t3_who0", ws[0], 0); chk("t3_who1", ws[1], 1);
      chk("t3_who2", ws[2], 0); chk("t3_who3", ws[3], 1);
      chk("t3_gap1", gs[1] - gs[0], 4);
      chk("t3_gap2", gs[2] - gs[1], 4);
      chk("t3_gap3", gs[3] - gs[2], 4);
    end
    repeat (6) @(posedge clk); #1;

    // Core request withdrawn while the port is busy
    issue(1, 0, 32'h80, '0, g);
    c_req = 1; c_we = 0; c_addr = 32'h99C;
    @(posedge clk); #1;
    @(posedge clk); #1 c_req = 0;
    hit = 0; n_cg = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_en && mem_addr == 32'h99C) hit++;
      n_cg += int'(c_gnt);
    end
    chk("t4_no_core_access", hit, 0);
    chk("t4_no_core_gnt", n_cg, 0);

    // Reset during the second ACCESS cycle
    @(posedge clk); #1;
    issue(0, 0, 32'h20, '0, g);
    @(posedge clk); #2 rst_n = 0;
    c_req = 1; c_addr = 32'h24; d_req = 1; d_addr = 32'h28;
    #1;
    chk("t5_async_en", mem_en, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_gnt_in_rst", c_gnt, 0);
    n_rv = 0;
    repeat (3) begin
      @(negedge clk);
      n_rv += int'(c_rvalid) + int'(d_rvalid);
    end
    chk("t5_no_rvalid", n_rv, 0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    chk("t5_busy_after", busy, 0);
    chk("t5_core_tie_c", c_gnt, 1);
    chk("t5_core_tie_d", d_gnt, 0);
    @(posedge clk); #1 c_req = 0; d_req = 0;
    repeat (6) @(posedge clk); #1;

    // MEM_LAT = 1 instance: back-to-back core reads
    p_c_req = 1; p_c_addr = 32'h10;
    bad_rd = 0; n_prv = 0;
    repeat (12) begin
      @(negedge clk);
      if (p_c_gnt) pg.push_back(cyc);
      if (p_c_rvalid) begin
        pr.push_back(cyc);
        if (p_c_rdata !== 32'hDEADBEEF) bad_rd++;
      end
      n_prv += int'(p_d_rvalid);
    end
    @(posedge clk); #1 p_c_req = 0;
    chk("t6_ngnt_ge3", pg.size() >= 3, 1);
    chk("t6_nrv_ge1", pr.size() >= 1, 1);
    if (pg.size() >= 3 && pr.size() >= 1) begin
      chk("t6_gap1", pg[1] - pg[0], 3);
      chk("t6_gap2", pg[2] - pg[1], 3);
      chk("t6_latency", pr[0] - pg[0], 2);
    end
    chk("t6_rdata", bad_rd, 0);
    chk("t6_no_d_rvalid", n_prv, 0);
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
